// File: rtl/datamover_package.sv
// Shared types for the datamover control path: streamer control/flag bundles,
// the job-sequencer state encoding, the latched job descriptor and the
// helper that builds a linear (single-dimension) address-generator setting.
package datamover_package;

  localparam int unsigned DM_LEN_W  = 16;
  localparam int unsigned DM_ADDR_W = 32;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    WORKING  = 3'd2,
    DRAIN    = 3'd3,
    FINISHED = 3'd4
  } datamover_state_e;

  typedef struct packed {
    logic [DM_ADDR_W-1:0] base_addr;
    logic [31:0]          tot_len;
    logic [31:0]          d0_len;
    logic [31:0]          d0_stride;
    logic [31:0]          d1_len;
    logic [31:0]          d1_stride;
    logic [31:0]          d2_stride;
  } addressgen_ctrl_t;

  typedef struct packed {
    logic             req_start;
    addressgen_ctrl_t addressgen_ctrl;
  } streamer_ctrl_t;

  typedef struct packed {
    logic ready_start;
    logic done;
  } streamer_flags_t;

  typedef struct packed {
    streamer_ctrl_t data_in_source_ctrl;
    streamer_ctrl_t data_out_sink_ctrl;
  } ctrl_streamer_t;

  typedef struct packed {
    streamer_flags_t data_in_source_flags;
    streamer_flags_t data_out_sink_flags;
    logic            tcdm_fifo_empty;
  } flags_streamer_t;

  typedef struct packed {
    logic [DM_ADDR_W-1:0] in_ptr;
    logic [DM_ADDR_W-1:0] out_ptr;
    logic [DM_LEN_W-1:0]  len;
  } datamover_job_t;

  // Linear transfer: one dimension of 'len' words, higher dimensions unused.
  function automatic addressgen_ctrl_t make_linear_ag(
    input logic [DM_ADDR_W-1:0] base,
    input logic [DM_LEN_W-1:0]  len,
    input logic [31:0]          stride
  );
    addressgen_ctrl_t ag;
    ag           = '0;
    ag.base_addr = base;
    ag.tot_len   = 32'(len);
    ag.d0_len    = 32'(len);
    ag.d0_stride = stride;
    return ag;
  endfunction

endpackage

// File: rtl/datamover_ctrl_fsm.sv
// Datamover job sequencer. Latches one job on start, launches the source and
// sink streamers together, collects both completions (sticky), waits for the
// TCDM FIFO to drain and then emits a single-cycle done event. A saturating
// counter records how many cycles the job kept the engine busy.
module datamover_ctrl_fsm
  import datamover_package::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_W      = DM_LEN_W,
  parameter int unsigned PERF_W     = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              start_i,
  input  logic [31:0]       cfg_in_ptr_i,
  input  logic [31:0]       cfg_out_ptr_i,
  input  logic [LEN_W-1:0]  cfg_len_i,
  output ctrl_streamer_t    ctrl_streamer_o,
  input  flags_streamer_t   flags_streamer_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [PERF_W-1:0] perf_cycles_o
);

  localparam logic [31:0] WORD_STRIDE = 32'(DATA_WIDTH / 8);

  datamover_state_e  state_r;
  datamover_job_t    job_r;
  logic              ag_valid_r;
  logic              src_done_r;
  logic              snk_done_r;
  logic              busy_r;
  logic              done_r;
  logic [PERF_W-1:0] perf_r;

  logic              both_ready_s;
  logic              src_done_seen_s;
  logic              snk_done_seen_s;
  logic              req_start_s;
  ctrl_streamer_t    ctrl_s;

  // Handshake decode and streamer control assembly from registered job state
  always_comb begin
    both_ready_s    = flags_streamer_i.data_in_source_flags.ready_start &
                      flags_streamer_i.data_out_sink_flags.ready_start;
    src_done_seen_s = src_done_r | flags_streamer_i.data_in_source_flags.done;
    snk_done_seen_s = snk_done_r | flags_streamer_i.data_out_sink_flags.done;
    req_start_s     = 1'b0;
    if (state_r == START) begin
      req_start_s = both_ready_s;
    end else begin
      req_start_s = 1'b0;
    end
    ctrl_s = '0;
    if (ag_valid_r) begin
      ctrl_s.data_in_source_ctrl.addressgen_ctrl =
        make_linear_ag(job_r.in_ptr, job_r.len, WORD_STRIDE);
      ctrl_s.data_out_sink_ctrl.addressgen_ctrl =
        make_linear_ag(job_r.out_ptr, job_r.len, WORD_STRIDE);
    end else begin
      ctrl_s.data_in_source_ctrl.addressgen_ctrl = '0;
      ctrl_s.data_out_sink_ctrl.addressgen_ctrl  = '0;
    end
    ctrl_s.data_in_source_ctrl.req_start = req_start_s;
    ctrl_s.data_out_sink_ctrl.req_start  = req_start_s;
  end

  // Job FSM with job registers, sticky completion flags and perf counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r    <= IDLE;
      job_r      <= '0;
      ag_valid_r <= 1'b0;
      src_done_r <= 1'b0;
      snk_done_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      perf_r     <= '0;
    end else if (clear_i) begin
      state_r    <= IDLE;
      job_r      <= '0;
      ag_valid_r <= 1'b0;
      src_done_r <= 1'b0;
      snk_done_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      perf_r     <= '0;
    end else begin
      // Count every busy cycle, FINISHED included; hold at all-ones.
      if (busy_r && (perf_r != '1)) begin
        perf_r <= perf_r + PERF_W'(1);
      end
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start_i) begin
            job_r.in_ptr  <= cfg_in_ptr_i;
            job_r.out_ptr <= cfg_out_ptr_i;
            job_r.len     <= DM_LEN_W'(cfg_len_i);
            perf_r        <= '0;
            busy_r        <= 1'b1;
            src_done_r    <= 1'b0;
            snk_done_r    <= 1'b0;
            if (cfg_len_i == '0) begin
              // Empty job: nothing to launch, report completion right away.
              ag_valid_r <= 1'b0;
              done_r     <= 1'b1;
              state_r    <= FINISHED;
            end else begin
              ag_valid_r <= 1'b1;
              state_r    <= START;
            end
          end
        end
        START: begin
          // Early (spurious) done pulses are kept so they are not lost.
          src_done_r <= src_done_seen_s;
          snk_done_r <= snk_done_seen_s;
          if (both_ready_s) begin
            state_r <= WORKING;
          end
        end
        WORKING: begin
          src_done_r <= src_done_seen_s;
          snk_done_r <= snk_done_seen_s;
          if (src_done_seen_s && snk_done_seen_s) begin
            state_r <= DRAIN;
          end
        end
        DRAIN: begin
          if (flags_streamer_i.tcdm_fifo_empty) begin
            done_r  <= 1'b1;
            state_r <= FINISHED;
          end
        end
        FINISHED: begin
          done_r     <= 1'b0;
          busy_r     <= 1'b0;
          ag_valid_r <= 1'b0;
          src_done_r <= 1'b0;
          snk_done_r <= 1'b0;
          state_r    <= IDLE;
        end
        default: begin
          state_r    <= IDLE;
          ag_valid_r <= 1'b0;
          src_done_r <= 1'b0;
          snk_done_r <= 1'b0;
          busy_r     <= 1'b0;
          done_r     <= 1'b0;
        end
      endcase
    end
  end

  assign ctrl_streamer_o = ctrl_s;
  assign busy_o          = busy_r;
  assign done_o          = done_r;
  assign perf_cycles_o   = perf_r;

endmodule

// File: tb/tb_datamover_ctrl_fsm.sv
// Self-checking bench for datamover_ctrl_fsm. Each job's expected timeline is
// computed up front from the job rules (launch cycle, drain entry, done cycle)
// and every cycle of the job is compared against it.
module tb_datamover_ctrl_fsm;
  import datamover_package::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            clear;
  logic            start;
  logic [31:0]     in_ptr;
  logic [31:0]     out_ptr;
  logic [15:0]     len;
  ctrl_streamer_t  ctrl;
  flags_streamer_t flags;
  logic            busy;
  logic            done;
  logic [31:0]     perf;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  datamover_ctrl_fsm #(
    .DATA_WIDTH(32),
    .LEN_W     (16),
    .PERF_W    (32)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .clear_i         (clear),
    .start_i         (start),
    .cfg_in_ptr_i    (in_ptr),
    .cfg_out_ptr_i   (out_ptr),
    .cfg_len_i       (len),
    .ctrl_streamer_o (ctrl),
    .flags_streamer_i(flags),
    .busy_o          (busy),
    .done_o          (done),
    .perf_cycles_o   (perf)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic idle_inputs();
    start   = 1'b0;
    clear   = 1'b0;
    in_ptr  = 32'h0;
    out_ptr = 32'h0;
    len     = 16'h0;
    flags   = '0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 256'(busy), 256'(1'b0));
    chk({tag, "_done"}, 256'(done), 256'(1'b0));
    chk({tag, "_perf"}, 256'(perf), 256'(32'd0));
    chk({tag, "_ctrl_nonzero"}, 256'(ctrl != '0), 256'(1'b0));
  endtask

  // One job: cycle 0 carries start_i; rs/rn = first cycle each ready_start is
  // high, ds/dn = done pulse cycles, fe = first cycle the FIFO reads empty.
  task automatic run_job(input string name, input logic [31:0] ip, input logic [31:0] op,
                         input int l, input int rs, input int rn, input int ds,
                         input int dn, input int fe, input bit poke);
    int r_c, d_c, e_c, f_c;
    addressgen_ctrl_t exp_src, exp_snk;
    logic exp_req, exp_busy, exp_done;
    r_c = 0;
    d_c = 0;
    if (l == 0) begin
      f_c = 1;
    end else begin
      r_c = imax(1, imax(rs, rn));
      d_c = imax(imax(ds, dn) + 1, r_c + 2);
      e_c = imax(d_c, fe);
      f_c = e_c + 1;
    end
    exp_src = '0;
    exp_src.base_addr = ip;
    exp_src.tot_len   = 32'(l);
    exp_src.d0_len    = 32'(l);
    exp_src.d0_stride = 32'd4;
    exp_snk = exp_src;
    exp_snk.base_addr = op;

    // Stray completions while idle must not be remembered.
    @(posedge clk); #1;
    flags.data_in_source_flags.done = 1'b1;
    flags.data_out_sink_flags.done  = 1'b1;
    @(negedge clk);
    chk({name, "_idle_busy"}, 256'(busy), 256'(1'b0));

    for (int c = 0; c <= f_c + 2; c++) begin
      @(posedge clk); #1;
      start = (c == 0) || (poke && (((l != 0) && (c == r_c + 1) && (r_c + 1 < d_c)) || (c == f_c)));
      if (c == 0) begin
        in_ptr  = ip;
        out_ptr = op;
        len     = 16'(l);
      end else begin
        in_ptr  = $urandom;
        out_ptr = $urandom;
        len     = 16'($urandom);
      end
      flags.data_in_source_flags.ready_start = (c >= rs);
      flags.data_out_sink_flags.ready_start  = (c >= rn);
      flags.data_in_source_flags.done        = (c == ds);
      flags.data_out_sink_flags.done         = (c == dn);
      flags.tcdm_fifo_empty                  = (c >= fe);
      @(negedge clk);
      exp_req  = (l != 0) && (c == r_c);
      exp_busy = (c >= 1) && (c <= f_c);
      exp_done = (c == f_c);
      chk($sformatf("%s_c%0d_req_src", name, c), 256'(ctrl.data_in_source_ctrl.req_start), 256'(exp_req));
      chk($sformatf("%s_c%0d_req_snk", name, c), 256'(ctrl.data_out_sink_ctrl.req_start), 256'(exp_req));
      chk($sformatf("%s_c%0d_busy", name, c), 256'(busy), 256'(exp_busy));
      chk($sformatf("%s_c%0d_done", name, c), 256'(done), 256'(exp_done));
      if (c >= 1) begin
        chk($sformatf("%s_c%0d_perf", name, c), 256'(perf), 256'((c <= f_c) ? (c - 1) : f_c));
      end
      if ((l != 0) && exp_busy) begin
        chk($sformatf("%s_c%0d_ag_src", name, c), 256'(ctrl.data_in_source_ctrl.addressgen_ctrl), 256'(exp_src));
        chk($sformatf("%s_c%0d_ag_snk", name, c), 256'(ctrl.data_out_sink_ctrl.addressgen_ctrl), 256'(exp_snk));
      end
    end
    idle_inputs();
  endtask

  // Abort a running job with rst_i (asynchronous) or clear_i (synchronous).
  task automatic run_abort(input bit use_rst);
    string tag;
    tag = use_rst ? "abort_rst" : "abort_clr";
    @(posedge clk); #1;
    start   = 1'b1;
    in_ptr  = 32'h0000_4000;
    out_ptr = 32'h0000_8000;
    len     = 16'd20;
    flags.data_in_source_flags.ready_start = 1'b1;
    flags.data_out_sink_flags.ready_start  = 1'b1;
    flags.tcdm_fifo_empty                  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "_pre_busy"}, 256'(busy), 256'(1'b1));
    @(posedge clk); #1;
    if (use_rst) rst = 1'b1;
    else clear = 1'b1;
    @(negedge clk);
    if (use_rst) check_zero({tag, "_now"});
    else chk({tag, "_sync_busy"}, 256'(busy), 256'(1'b1));
    @(posedge clk); #1;
    rst   = 1'b0;
    clear = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_zero($sformatf("%s_after%0d", tag, c));
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_zero("reset_held");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_zero("reset_state");

    run_job("t1_basic",  32'h0000_1000, 32'h0000_2000, 64, 0, 0, 2, 2, 0, 1'b0);
    run_job("t2_ready",  32'h0000_3000, 32'h0000_5000, 16, 0, 5, 8, 8, 0, 1'b0);
    run_job("t3_drain",  32'h0000_1000, 32'h0000_2000, 64, 0, 0, 10, 25, 30, 1'b0);
    run_job("t4_len0",   32'h0000_7000, 32'h0000_9000, 0, 0, 0, 1, 2, 0, 1'b0);
    run_job("t5_poke",   32'hABCD_0000, 32'h1234_0000, 300, 1, 2, 6, 9, 12, 1'b1);
    run_job("t5b_early", 32'h0000_0100, 32'h0000_0200, 8, 3, 3, 1, 2, 0, 1'b0);
    run_abort(1'b1);
    run_job("t6_after_rst", 32'h0000_0A00, 32'h0000_0B00, 5, 0, 0, 3, 4, 6, 1'b0);
    run_abort(1'b0);
    run_job("t6_after_clr", 32'h0000_0C00, 32'h0000_0D00, 7, 0, 1, 4, 3, 0, 1'b0);
    run_job("t7_max_len", 32'hFFFF_FFFC, 32'h0000_0000, 65535, 2, 0, 5, 5, 5, 1'b1);

    for (int j = 0; j < 20; j++) begin
      int l;
      l = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 65535));
      run_job($sformatf("rnd%0d", j), $urandom, $urandom, l,
              int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
              int'($urandom_range(1, 20)), int'($urandom_range(1, 20)),
              int'($urandom_range(0, 35)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
